// File: rtl/id_stage_pipelined_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipelined_if
// Handshake and bus bundle for the registered RV32I decode stage.
//   Fetch side  : if_valid, if_instruction, if_pc  -> stage; id_ready <- stage
//   Control     : flush (redirect), ex_ready (execute accepts ID/EX)
//   Execute side: ex_valid plus the registered decode fields (ex_*)
// Modports:
//   master - the environment around the stage (fetch, execute, redirect)
//   slave  - the decode stage itself
// ---------------------------------------------------------------------------
interface id_stage_pipelined_if #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH       = 4
);
    logic                          if_valid;
    logic [REG_DATA_WIDTH-1:0]     if_instruction;
    logic [REG_DATA_WIDTH-1:0]     if_pc;
    logic                          id_ready;
    logic                          flush;
    logic                          ex_ready;
    logic                          ex_valid;
    logic [REG_DATA_WIDTH-1:0]     ex_pc;
    logic [ALU_OP_WIDTH-1:0]       ex_alu_op;
    logic                          ex_alu_src_imm;
    logic                          ex_alu_src_pc;
    logic [REG_DATA_WIDTH-1:0]     ex_immediate;
    logic                          ex_rd_wr_en;
    logic                          ex_mem_rd;
    logic                          ex_mem_wr;
    logic                          ex_branch;
    logic                          ex_jump;
    logic [2:0]                    ex_funct3;
    logic [REGFILE_ADDR_WIDTH-1:0] ex_rd;
    logic [REGFILE_ADDR_WIDTH-1:0] ex_rs1;
    logic [REGFILE_ADDR_WIDTH-1:0] ex_rs2;
    logic                          ex_illegal;

    modport master (
        output if_valid, if_instruction, if_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_alu_op, ex_alu_src_imm, ex_alu_src_pc,
               ex_immediate, ex_rd_wr_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
               ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_illegal
    );

    modport slave (
        input  if_valid, if_instruction, if_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_alu_op, ex_alu_src_imm, ex_alu_src_pc,
               ex_immediate, ex_rd_wr_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump,
               ex_funct3, ex_rd, ex_rs1, ex_rs2, ex_illegal
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// ---------------------------------------------------------------------------
// id_stage_pipelined
// Registered RV32I decode stage owning the ID/EX pipeline register.
// Decodes the fetched instruction combinationally into control flags and a
// sign-extended immediate, captures it into ID/EX on advance, inserts a
// one-cycle bubble on a load-use hazard and kills ID/EX on a redirect.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset (clears ID/EX)
//   bus  - id_stage_pipelined_if.slave: fetch handshake (if_valid,
//          if_instruction, if_pc, id_ready), flush, ex_ready and the
//          registered ID/EX outputs (ex_valid, ex_pc, ex_alu_op, ...)
// ALU opcodes: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 SEQ=10
// ---------------------------------------------------------------------------
module id_stage_pipelined #(
    parameter int REG_DATA_WIDTH     = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH       = 4,
    parameter bit HAZARD_EN          = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    id_stage_pipelined_if.slave  bus
);
    localparam int W  = REG_DATA_WIDTH;
    localparam int RA = REGFILE_ADDR_WIDTH;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = alu_op_t'(0);
    localparam alu_op_t ALU_SUB  = alu_op_t'(1);
    localparam alu_op_t ALU_SLL  = alu_op_t'(2);
    localparam alu_op_t ALU_SLT  = alu_op_t'(3);
    localparam alu_op_t ALU_SLTU = alu_op_t'(4);
    localparam alu_op_t ALU_XOR  = alu_op_t'(5);
    localparam alu_op_t ALU_SRL  = alu_op_t'(6);
    localparam alu_op_t ALU_SRA  = alu_op_t'(7);
    localparam alu_op_t ALU_OR   = alu_op_t'(8);
    localparam alu_op_t ALU_AND  = alu_op_t'(9);
    localparam alu_op_t ALU_SEQ  = alu_op_t'(10);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Field extraction
    logic [31:0]   instr;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [RA-1:0] rd;
    logic [RA-1:0] rs1_raw;
    logic [RA-1:0] rs2;

    assign instr   = bus.if_instruction[31:0];
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd      = RA'(instr[11:7]);
    assign rs1_raw = RA'(instr[19:15]);
    assign rs2     = RA'(instr[24:20]);

    // Immediates, all sign-extended from instr[31]
    logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(W-11){instr[31]}}, instr[30:20]};
    assign imm_s = {{(W-11){instr[31]}}, instr[30:25], instr[11:7]};
    assign imm_b = {{(W-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(W-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(W-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Combinational decode
    alu_op_t       d_alu_op;
    logic          d_src_imm, d_src_pc;
    logic [W-1:0]  d_imm;
    logic          d_rd_wr_en, d_mem_rd, d_mem_wr, d_branch, d_jump, d_illegal;
    logic [RA-1:0] d_rs1;

    always_comb begin
        d_alu_op   = ALU_ADD;
        d_src_imm  = 1'b0;
        d_src_pc   = 1'b0;
        d_imm      = '0;
        d_rd_wr_en = 1'b0;
        d_mem_rd   = 1'b0;
        d_mem_wr   = 1'b0;
        d_branch   = 1'b0;
        d_jump     = 1'b0;
        d_illegal  = 1'b0;
        d_rs1      = rs1_raw;

        case (opcode)
            OPC_LUI: begin
                // Computed as x0 + imm so the ALU path is shared with AUIPC.
                d_rs1      = '0;
                d_src_imm  = 1'b1;
                d_imm      = imm_u;
                d_rd_wr_en = 1'b1;
            end
            OPC_AUIPC: begin
                d_src_pc   = 1'b1;
                d_src_imm  = 1'b1;
                d_imm      = imm_u;
                d_rd_wr_en = 1'b1;
            end
            OPC_JAL: begin
                d_src_pc   = 1'b1;
                d_src_imm  = 1'b1;
                d_imm      = imm_j;
                d_rd_wr_en = 1'b1;
                d_jump     = 1'b1;
            end
            OPC_JALR: begin
                d_src_imm  = 1'b1;
                d_imm      = imm_i;
                d_rd_wr_en = 1'b1;
                d_jump     = 1'b1;
                d_illegal  = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_imm    = imm_b;
                d_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   d_alu_op = ALU_SEQ;
                    2'b10:   d_alu_op = ALU_SLT;
                    2'b11:   d_alu_op = ALU_SLTU;
                    default: d_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_src_imm  = 1'b1;
                d_imm      = imm_i;
                d_rd_wr_en = 1'b1;
                d_mem_rd   = 1'b1;
                d_illegal  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                d_src_imm = 1'b1;
                d_imm     = imm_s;
                d_mem_wr  = 1'b1;
                d_illegal = funct3[2] || (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                d_src_imm  = 1'b1;
                d_imm      = imm_i;
                d_rd_wr_en = 1'b1;
                // instr[30] is an immediate bit except for the right shifts.
                d_alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
                if (funct3 == 3'b001)
                    d_illegal = (funct7 != F7_ZERO);
                else if (funct3 == 3'b101)
                    d_illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                d_rd_wr_en = 1'b1;
                d_alu_op   = alu_from_funct3(funct3, instr[30]);
                d_illegal  = !((funct7 == F7_ZERO) ||
                               ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_FENCE: begin
                // Single in-order pipe: FENCE is a legal no-op.
            end
            default: begin
                // SYSTEM and all other opcodes go to execute as illegal so it traps.
                d_illegal = 1'b1;
            end
        endcase

        if (d_illegal) begin
            d_alu_op   = ALU_ADD;
            d_src_imm  = 1'b0;
            d_src_pc   = 1'b0;
            d_imm      = '0;
            d_rd_wr_en = 1'b0;
            d_mem_rd   = 1'b0;
            d_mem_wr   = 1'b0;
            d_branch   = 1'b0;
            d_jump     = 1'b0;
        end

        if (rd == '0)
            d_rd_wr_en = 1'b0;
    end

    // Handshake and load-use hazard against the instruction held in ID/EX
    logic adv;
    logic uses_rs2;
    logic hazard_raw;
    logic hazard;

    assign adv        = !bus.ex_valid || bus.ex_ready;
    assign uses_rs2   = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign hazard_raw = bus.ex_valid && bus.ex_mem_rd && (bus.ex_rd != '0) &&
                        ((bus.ex_rd == d_rs1) || (uses_rs2 && (bus.ex_rd == rs2)));
    assign hazard     = HAZARD_EN && hazard_raw;
    assign bus.id_ready = adv && !hazard;

    // ID/EX register; fields other than ex_valid hold across bubbles and flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid       <= 1'b0;
            bus.ex_pc          <= '0;
            bus.ex_alu_op      <= '0;
            bus.ex_alu_src_imm <= 1'b0;
            bus.ex_alu_src_pc  <= 1'b0;
            bus.ex_immediate   <= '0;
            bus.ex_rd_wr_en    <= 1'b0;
            bus.ex_mem_rd      <= 1'b0;
            bus.ex_mem_wr      <= 1'b0;
            bus.ex_branch      <= 1'b0;
            bus.ex_jump        <= 1'b0;
            bus.ex_funct3      <= '0;
            bus.ex_rd          <= '0;
            bus.ex_rs1         <= '0;
            bus.ex_rs2         <= '0;
            bus.ex_illegal     <= 1'b0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
        end else if (adv) begin
            if (hazard || !bus.if_valid) begin
                bus.ex_valid <= 1'b0;
            end else begin
                bus.ex_valid       <= 1'b1;
                bus.ex_pc          <= bus.if_pc;
                bus.ex_alu_op      <= d_alu_op;
                bus.ex_alu_src_imm <= d_src_imm;
                bus.ex_alu_src_pc  <= d_src_pc;
                bus.ex_immediate   <= d_imm;
                bus.ex_rd_wr_en    <= d_rd_wr_en;
                bus.ex_mem_rd      <= d_mem_rd;
                bus.ex_mem_wr      <= d_mem_wr;
                bus.ex_branch      <= d_branch;
                bus.ex_jump        <= d_jump;
                bus.ex_funct3      <= funct3;
                bus.ex_rd          <= rd;
                bus.ex_rs1         <= d_rs1;
                bus.ex_rs2         <= rs2;
                bus.ex_illegal     <= d_illegal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_pipelined.sv
module tb_id_stage_pipelined;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipelined_if bus0 ();
    id_stage_pipelined_if bus1 ();

    id_stage_pipelined #(.HAZARD_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    id_stage_pipelined #(.HAZARD_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct packed {
        logic [3:0]  alu;
        logic        src_imm, src_pc, rd_wr, mem_rd, mem_wr, branch, jump, illegal;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    dec_t act0, act1;
    assign act0 = {bus0.ex_alu_op, bus0.ex_alu_src_imm, bus0.ex_alu_src_pc, bus0.ex_rd_wr_en,
                   bus0.ex_mem_rd, bus0.ex_mem_wr, bus0.ex_branch, bus0.ex_jump, bus0.ex_illegal,
                   bus0.ex_immediate, bus0.ex_rd, bus0.ex_rs1, bus0.ex_rs2, bus0.ex_funct3};
    assign act1 = {bus1.ex_alu_op, bus1.ex_alu_src_imm, bus1.ex_alu_src_pc, bus1.ex_rd_wr_en,
                   bus1.ex_mem_rd, bus1.ex_mem_wr, bus1.ex_branch, bus1.ex_jump, bus1.ex_illegal,
                   bus1.ex_immediate, bus1.ex_rd, bus1.ex_rs1, bus1.ex_rs2, bus1.ex_funct3};

    int n_checks;
    int n_errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cmp_dec(input string tag, input dec_t a, input dec_t e);
        chk({tag, " alu_op"}, 32'(a.alu), 32'(e.alu));
        chk({tag, " flags[imm,pc,wr,ld,st,br,j,ill]"},
            32'({a.src_imm, a.src_pc, a.rd_wr, a.mem_rd, a.mem_wr, a.branch, a.jump, a.illegal}),
            32'({e.src_imm, e.src_pc, e.rd_wr, e.mem_rd, e.mem_wr, e.branch, e.jump, e.illegal}));
        chk({tag, " immediate"}, a.imm, e.imm);
        chk({tag, " rd"}, 32'(a.rd), 32'(e.rd));
        chk({tag, " rs1"}, 32'(a.rs1), 32'(e.rs1));
        chk({tag, " rs2"}, 32'(a.rs2), 32'(e.rs2));
        chk({tag, " funct3"}, 32'(a.f3), 32'(e.f3));
    endtask

    // Flag letters: I src_imm, P src_pc, W rd_wr_en, L mem_rd, S mem_wr, B branch, J jump, X illegal
    function automatic dec_t mk(input int alu, input string fl, input logic [31:0] imm,
                                input int rd, input int rs1, input int rs2, input int f3);
        dec_t d = '0;
        d.alu = 4'(alu);
        d.imm = imm;
        d.rd  = 5'(rd);
        d.rs1 = 5'(rs1);
        d.rs2 = 5'(rs2);
        d.f3  = 3'(f3);
        for (int i = 0; i < fl.len(); i++) begin
            case (fl[i])
                "I": d.src_imm = 1'b1;
                "P": d.src_pc  = 1'b1;
                "W": d.rd_wr   = 1'b1;
                "L": d.mem_rd  = 1'b1;
                "S": d.mem_wr  = 1'b1;
                "B": d.branch  = 1'b1;
                "J": d.jump    = 1'b1;
                "X": d.illegal = 1'b1;
                default: ;
            endcase
        end
        return d;
    endfunction

    // Reference decoder written from the ISA rules
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t        d;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [3:0]  rop [8];
        bit          ok;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        i_imm = $signed(ins) >>> 20;
        s_imm = {i_imm[31:5], ins[11:7]};
        b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = ins & 32'hFFFF_F000;
        j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        rop = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        d = '0;
        d.rd  = ins[11:7];
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.f3  = f3;
        ok = 1'b1;
        case (op)
            7'h37: begin d.rs1 = 5'd0; d.imm = u_imm; d.src_imm = 1'b1; d.rd_wr = 1'b1; end
            7'h17: begin d.imm = u_imm; d.src_imm = 1'b1; d.src_pc = 1'b1; d.rd_wr = 1'b1; end
            7'h6F: begin d.imm = j_imm; d.src_imm = 1'b1; d.src_pc = 1'b1; d.rd_wr = 1'b1; d.jump = 1'b1; end
            7'h67: begin ok = (f3 == 3'd0); d.imm = i_imm; d.src_imm = 1'b1; d.rd_wr = 1'b1; d.jump = 1'b1; end
            7'h63: begin
                ok = !(f3 == 3'd2 || f3 == 3'd3);
                d.imm = b_imm;
                d.branch = 1'b1;
                d.alu = (f3 < 3'd2) ? 4'd10 : (f3 < 3'd6) ? 4'd3 : 4'd4;
            end
            7'h03: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                d.imm = i_imm; d.src_imm = 1'b1; d.rd_wr = 1'b1; d.mem_rd = 1'b1;
            end
            7'h23: begin ok = (f3 <= 3'd2); d.imm = s_imm; d.src_imm = 1'b1; d.mem_wr = 1'b1; end
            7'h13: begin
                d.imm = i_imm; d.src_imm = 1'b1; d.rd_wr = 1'b1;
                d.alu = rop[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    ok = f7 inside {7'h00, 7'h20};
                    if (f7 == 7'h20) d.alu = 4'd7;
                end
            end
            7'h33: begin
                d.rd_wr = 1'b1;
                d.alu = rop[f3];
                if (f7 == 7'h20) begin
                    ok = (f3 == 3'd0 || f3 == 3'd5);
                    d.alu = (f3 == 3'd0) ? 4'd1 : 4'd7;
                end else begin
                    ok = (f7 == 7'h00);
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d.alu = 4'd0; d.imm = '0;
            {d.src_imm, d.src_pc, d.rd_wr, d.mem_rd, d.mem_wr, d.branch, d.jump} = '0;
            d.illegal = 1'b1;
        end
        if (d.rd == 5'd0) d.rd_wr = 1'b0;
        return d;
    endfunction

    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int sel;
        ins = $urandom();
        sel = $urandom_range(0, 12);
        case (sel)
            0:       ins[6:0] = 7'h37;
            1:       ins[6:0] = 7'h17;
            2:       ins[6:0] = 7'h6F;
            3:       ins[6:0] = 7'h67;
            4:       ins[6:0] = 7'h63;
            5, 6:    ins[6:0] = 7'h03;
            7:       ins[6:0] = 7'h23;
            8:       ins[6:0] = 7'h13;
            9, 10:   ins[6:0] = 7'h33;
            11:      ins[6:0] = 7'h7F;
            default: ins[6:0] = 7'h0B;
        endcase
        if ($urandom_range(0, 3) != 0) begin
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
        end
        if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        if (ins[6:0] == 7'h03 && $urandom_range(0, 1) != 0)
            ins[14:12] = 3'd2;
        return ins;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic fl, input logic er);
        bus0.if_valid = v; bus0.if_instruction = ins; bus0.if_pc = pc; bus0.flush = fl; bus0.ex_ready = er;
        bus1.if_valid = v; bus1.if_instruction = ins; bus1.if_pc = pc; bus1.flush = fl; bus1.ex_ready = er;
    endtask

    vec_t vec [14];

    bit          m_valid [2];
    dec_t        m_dec   [2];
    logic [31:0] m_pc    [2];

    initial begin
        logic        r_v, r_er, r_fl, adv, hz;
        logic [31:0] r_ins, r_pc;
        dec_t        inc;

        n_checks = 0;
        n_errors = 0;

        vec[0]  = '{32'h00500093, mk(0,  "IW",   32'h5,        1,  0, 5, 0)};  // ADDI x1,x0,5
        vec[1]  = '{32'h402081B3, mk(1,  "W",    32'h0,        3,  1, 2, 0)};  // SUB x3,x1,x2
        vec[2]  = '{32'h002081B3, mk(0,  "W",    32'h0,        3,  1, 2, 0)};  // ADD x3,x1,x2
        vec[3]  = '{32'hFE208EE3, mk(10, "B",    32'hFFFFFFFC, 29, 1, 2, 0)};  // BEQ x1,x2,-4
        vec[4]  = '{32'h0050A423, mk(0,  "IS",   32'h8,        8,  1, 5, 2)};  // SW x5,8(x1)
        vec[5]  = '{32'h0000A283, mk(0,  "IWL",  32'h0,        5,  1, 0, 2)};  // LW x5,0(x1)
        vec[6]  = '{32'h123453B7, mk(0,  "IW",   32'h12345000, 7,  0, 3, 5)};  // LUI x7,0x12345
        vec[7]  = '{32'h00001117, mk(0,  "IPW",  32'h1000,     2,  0, 0, 1)};  // AUIPC x2,1
        vec[8]  = '{32'h008000EF, mk(0,  "IPWJ", 32'h8,        1,  0, 8, 0)};  // JAL x1,8
        vec[9]  = '{32'h00008067, mk(0,  "IJ",   32'h0,        0,  1, 0, 0)};  // JALR x0,0(x1)
        vec[10] = '{32'h0000007F, mk(0,  "X",    32'h0,        0,  0, 0, 0)};  // opcode 0x7F
        vec[11] = '{32'h40325213, mk(7,  "IW",   32'h403,      4,  4, 3, 5)};  // SRAI x4,x4,3
        vec[12] = '{32'h0020B1B3, mk(4,  "W",    32'h0,        3,  1, 2, 3)};  // SLTU x3,x1,x2
        vec[13] = '{32'h202081B3, mk(0,  "X",    32'h0,        3,  1, 2, 0)};  // bad funct7

        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset ex_valid", 32'(bus0.ex_valid), 32'd0);
        chk("reset id_ready", 32'(bus0.id_ready), 32'd1);
        chk("reset ex_pc", bus0.ex_pc, 32'd0);
        cmp_dec("reset", act0, '0);
        chk("reset nohz id_ready", 32'(bus1.id_ready), 32'd1);

        // Table of single-instruction decodes, one per cycle with ex_ready=1
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_in(1'b1, vec[i].instr, 32'h100 + 32'(4 * i), 1'b0, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d ex_valid", i), 32'(bus0.ex_valid), 32'd1);
            chk($sformatf("tbl%0d ex_pc", i), bus0.ex_pc, 32'h100 + 32'(4 * i));
            cmp_dec($sformatf("tbl%0d", i), act0, vec[i].exp);
        end

        // Load-use: LW x5 then ADD x6,x5,x5
        @(negedge clk);
        set_in(1'b1, 32'h0000A283, 32'h200, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b1, 32'h00528333, 32'h204, 1'b0, 1'b1);
        #1;
        chk("loaduse id_ready stalled", 32'(bus0.id_ready), 32'd0);
        chk("loaduse nohz id_ready", 32'(bus1.id_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("loaduse bubble ex_valid", 32'(bus0.ex_valid), 32'd0);
        chk("loaduse nohz ex_valid", 32'(bus1.ex_valid), 32'd1);
        chk("loaduse nohz ex_rd", 32'(bus1.ex_rd), 32'd6);
        @(negedge clk);
        #1;
        chk("loaduse id_ready after bubble", 32'(bus0.id_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("loaduse issue ex_valid", 32'(bus0.ex_valid), 32'd1);
        chk("loaduse issue ex_rd", 32'(bus0.ex_rd), 32'd6);
        chk("loaduse issue ex_pc", bus0.ex_pc, 32'h204);

        // Execute back-pressure for 3 cycles, then flush during the stall
        @(negedge clk);
        set_in(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b1, 32'h402081B3, 32'h304, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d id_ready", c), 32'(bus0.id_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d ex_valid", c), 32'(bus0.ex_valid), 32'd1);
            chk($sformatf("stall%0d ex_pc", c), bus0.ex_pc, 32'h300);
            cmp_dec($sformatf("stall%0d", c), act0, vec[0].exp);
            @(negedge clk);
        end
        set_in(1'b1, 32'h402081B3, 32'h304, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("flush ex_valid", 32'(bus0.ex_valid), 32'd0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("idle ex_valid", 32'(bus0.ex_valid), 32'd0);

        // Asynchronous reset between clock edges
        @(negedge clk);
        set_in(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("pre-async ex_valid", 32'(bus0.ex_valid), 32'd1);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ex_valid", 32'(bus0.ex_valid), 32'd0);
        chk("async rst ex_rd", 32'(bus0.ex_rd), 32'd0);
        chk("async rst ex_immediate", bus0.ex_immediate, 32'd0);
        chk("async rst id_ready", 32'(bus0.id_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the reference model, both hazard settings
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_dec[k]   = '0;
            m_pc[k]    = '0;
        end
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            r_v   = ($urandom_range(0, 3) != 0);
            r_er  = ($urandom_range(0, 3) != 0);
            r_fl  = ($urandom_range(0, 19) == 0);
            r_ins = rand_instr();
            r_pc  = $urandom() & 32'hFFFF_FFFC;
            set_in(r_v, r_ins, r_pc, r_fl, r_er);
            #1;
            inc = ref_decode(r_ins);
            for (int k = 0; k < 2; k++) begin
                adv = !m_valid[k] || r_er;
                hz  = (k == 0) && m_valid[k] && m_dec[k].mem_rd && (m_dec[k].rd != 5'd0) &&
                      ((m_dec[k].rd == inc.rs1) || (reads_rs2(r_ins) && (m_dec[k].rd == inc.rs2)));
                chk($sformatf("rnd%0d c%0d id_ready", k, c),
                    32'((k == 0) ? bus0.id_ready : bus1.id_ready), 32'(adv && !hz));
                if (r_fl)
                    m_valid[k] = 1'b0;
                else if (adv && (hz || !r_v))
                    m_valid[k] = 1'b0;
                else if (adv) begin
                    m_valid[k] = 1'b1;
                    m_dec[k]   = inc;
                    m_pc[k]    = r_pc;
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("rnd0 c%0d ex_valid", c), 32'(bus0.ex_valid), 32'(m_valid[0]));
            chk($sformatf("rnd1 c%0d ex_valid", c), 32'(bus1.ex_valid), 32'(m_valid[1]));
            if (m_valid[0]) begin
                chk($sformatf("rnd0 c%0d ex_pc", c), bus0.ex_pc, m_pc[0]);
                cmp_dec($sformatf("rnd0 c%0d", c), act0, m_dec[0]);
            end
            if (m_valid[1]) begin
                chk($sformatf("rnd1 c%0d ex_pc", c), bus1.ex_pc, m_pc[1]);
                cmp_dec($sformatf("rnd1 c%0d", c), act1, m_dec[1]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Registered RV32I decode stage that sits between fetch and execute and owns the ID/EX pipeline register. It decodes all RV32I base opcodes into control signals and the sign-extended immediate, with a valid/ready handshake on both sides. It also detects load-use hazards against the instruction currently held in ID/EX and inserts a bubble when one is found, and it flushes on a redirect.

Parameters:
REG_DATA_WIDTH, 32, instruction/data/PC width
REGFILE_ADDR_WIDTH, 5, register index width
ALU_OP_WIDTH, 4, ALU opcode width
HAZARD_EN, 1, 1 = load-use stall logic present; 0 = never stall for hazards

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_instruction  in  REG_DATA_WIDTH  raw instruction
if_pc  in  REG_DATA_WIDTH  PC of the instruction
id_ready  out  1  stage accepts the instruction this cycle (combinational)
flush  in  1  branch/jump redirect; kill ID/EX contents
ex_ready  in  1  execute accepts the ID/EX contents
ex_valid  out  1  ID/EX holds a live instruction
ex_pc  out  REG_DATA_WIDTH  registered PC
ex_alu_op  out  ALU_OP_WIDTH  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 SEQ=10
ex_alu_src_imm  out  1  operand 2 is the immediate
ex_alu_src_pc  out  1  operand 1 is the PC (AUIPC, JAL)
ex_immediate  out  REG_DATA_WIDTH  sign-extended I/S/B/U/J immediate
ex_rd_wr_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump  out  1 each  control flags
ex_funct3  out  3  passed through for branch condition and load/store size
ex_rd, ex_rs1, ex_rs2  out  REGFILE_ADDR_WIDTH  register indices
ex_illegal  out  1  unrecognised opcode/funct combination

Behaviour:
- Reset (async, rst=1): every ex_* output is 0, ex_valid=0. id_ready is a function of the cleared state, so it is 1 after reset.
- Decode uses opcode[6:0], funct3, and instr[30] for SUB/SRA/SRAI. Decode is combinational from if_instruction and is captured into ID/EX on a load.
- Immediates:
  - I: OP_IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC; instr[31:12] << 12.
  - J: JAL, bit 0 = 0.
  - R-type: immediate = 0.
- Per-opcode decode:
  - LUI: ADD with rs1 forced to 0, src_imm=1.
  - AUIPC/JAL: ADD, src_pc=1, src_imm=1.
  - JAL and JALR: jump=1, rd_wr_en=1.
  - BRANCH: BEQ/BNE→SEQ, BLT/BGE→SLT, BLTU/BGEU→SLTU; rd_wr_en=0, branch=1.
  - LOAD/STORE: ADD, src_imm=1, mem_rd/mem_wr set; STORE has rd_wr_en=0.
- rd_wr_en is forced 0 when rd = 0.
- Illegal encodings: ex_illegal=1, all write/mem/branch/jump enables 0, ex_valid=1 so execute can trap.
- ID/EX advance condition: adv = !ex_valid | ex_ready.
- Hazard (HAZARD_EN=1): hazard = ex_valid & ex_mem_rd & (ex_rd≠0) & (ex_rd == rs1 | ex_rd == rs2 of the incoming instruction), where rs2 counts only for R/S/B formats.
- id_ready = adv & !hazard.
- Clock edge priority:
  1. flush → ex_valid←0 (highest; the incoming instruction is dropped and id_ready is ignored).
  2. adv & hazard → ex_valid←0 (bubble); fetch holds its instruction.
  3. adv & if_valid → load decode, ex_valid←1.
  4. adv & !if_valid → ex_valid←0.
  5. otherwise hold all ex_* stable.
- A load-use stall lasts exactly 1 cycle when ex_ready=1.
- Latency: an instruction accepted at edge N appears on ex_* after edge N.
- Mid-operation reset clears ID/EX immediately, without waiting for a clock edge.

Test Plan:
- ADDI x1,x0,5 (0x00500093), if_valid=1, ex_ready=1 → next cycle ex_valid=1, alu_op=0, imm=5, rd=1, src_imm=1, rd_wr_en=1.
- SUB x3,x1,x2 (0x402081B3) → alu_op=1, src_imm=0, rd=3, rs1=1, rs2=2; with instr[30]=0 (0x002081B3) → alu_op=0.
- BEQ x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, alu_op=10, branch=1, rd_wr_en=0.
- LW x5,0(x1) (0x0000A283) followed by ADD x6,x5,x5 (0x00528333) → id_ready=0 for one cycle, one bubble (ex_valid=0), then the ADD is issued. With HAZARD_EN=0 → no bubble.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* stable, id_ready=0. flush=1 during the stall → ex_valid=0 on the next edge.
- Opcode 0x7F → ex_illegal=1, rd_wr_en=0. Asserting rst asynchronously mid-stream → ex_valid=0 immediately.
